valid_ready_rr_arbiter: RTL and testbench

- Round-robin arbiter that merges NUM_REQ valid/ready producer streams onto one valid/ready channel. Typical sink is the sender side of async_fifo_valid_ready_wrapper.
- Grants are packet-aware: the grant stays locked until the beat marked last, or until MAX_BURST beats, whichever comes first.
- One registered output stage; the source id travels with each beat so the far clock domain can demultiplex.

---
 rtl/datatypes_globals_pkg.sv | 26 ++
 rtl/valid_ready_rr_arbiter_pick.sv | 29 ++
 rtl/valid_ready_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_valid_ready_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datatypes_globals_pkg.sv
// Shared datapath types for the streaming library: default payload, arbiter FSM state
// and the registered beat held in an arbiter output stage.
package datatypes_globals_pkg;

    typedef logic [7:0] rtl_data_t;

    // Widest requester id any library arbiter needs (up to 16 requesters).
    localparam int ARB_ID_W = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    typedef struct packed {
        rtl_data_t           data;
        logic [ARB_ID_W-1:0] id;
        logic                last;
    } arb_beat_t;

    // Beat counter width: enough to hold MAX_BURST-1, never narrower than one bit.
    function automatic int arb_cnt_width(input int max_burst);
        return (max_burst <= 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/valid_ready_rr_arbiter_pick.sv
// Round-robin pick: first requester at or after prev_id+1 (circular); purely combinational,
// no backpressure of its own -- the caller decides whether the pick is used.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    prev_id,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_id = '0;
        idx      = '0;
        // Scan farthest-to-nearest so the nearest active requester is the last one written.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(prev_id) + k) % NUM_REQ);
            if (req[idx]) begin
                grant_id = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// Packet-aware round-robin merge of NUM_REQ valid/ready streams; one registered stage, 1-cycle latency,
// full throughput; a stalled output holds its beat and withdraws every in_ready.
module valid_ready_rr_arbiter
    import datatypes_globals_pkg::*;
#(
    parameter type DATA_T       = rtl_data_t,
    parameter int  NUM_REQ      = 4,
    parameter int  REQ_ID_WIDTH = $clog2(NUM_REQ),
    parameter int  MAX_BURST    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      in_valid,
    output logic [NUM_REQ-1:0]      in_ready,
    input  DATA_T [NUM_REQ-1:0]     in_data,
    input  logic [NUM_REQ-1:0]      in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output DATA_T                   out_data,
    output logic [REQ_ID_WIDTH-1:0] out_id,
    output logic                    out_last
);

    localparam int                 CNT_W     = arb_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [REQ_ID_WIDTH-1:0] LAST_ID = REQ_ID_WIDTH'(NUM_REQ - 1);

    // Same shape as arb_beat_t, sized to this instance's payload and id width.
    typedef struct packed {
        DATA_T                   data;
        logic [REQ_ID_WIDTH-1:0] id;
        logic                    last;
    } beat_t;

    arb_state_e              state_q,     state_d;
    logic [REQ_ID_WIDTH-1:0] locked_id_q, locked_id_d;
    logic [REQ_ID_WIDTH-1:0] prev_id_q,   prev_id_d;
    logic [CNT_W-1:0]        beat_cnt_q,  beat_cnt_d;
    logic                    out_valid_q, out_valid_d;
    beat_t                   out_q,       out_d;

    logic [REQ_ID_WIDTH-1:0] pick_id;
    logic                    pick_any;
    logic [REQ_ID_WIDTH-1:0] cand;
    logic                    cand_ok;
    logic                    stage_free;
    logic                    accept;
    logic                    burst_end;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_WIDTH)
    ) u_pick (
        .req      (in_valid),
        .prev_id  (prev_id_q),
        .grant_id (pick_id),
        .any_req  (pick_any)
    );

    assign stage_free = !out_valid_q || out_ready;

    always_comb begin
        cand    = pick_id;
        cand_ok = pick_any;
        // A locked requester keeps the grant even while its valid is low; the others are ignored.
        if (state_q == LOCKED) begin
            cand    = locked_id_q;
            cand_ok = 1'b1;
        end
    end

    always_comb begin
        in_ready = '0;
        if (cand_ok && stage_free && reset_n) begin
            in_ready[cand] = 1'b1;
        end
    end

    assign accept    = in_valid[cand] && in_ready[cand];
    assign burst_end = in_last[cand] || ((MAX_BURST != 0) && (beat_cnt_q == LAST_BEAT));

    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        prev_id_d   = prev_id_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = '{data: in_data[cand], id: cand, last: burst_end};
            prev_id_d   = cand;
            if (burst_end) begin
                beat_cnt_d = '0;
                state_d    = UNLOCKED;
            end else begin
                beat_cnt_d  = (MAX_BURST == 0) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
                locked_id_d = cand;
                state_d     = LOCKED;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNLOCKED;
            locked_id_q <= '0;
            prev_id_q   <= LAST_ID;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            prev_id_q   <= prev_id_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_id    = out_q.id;
    assign out_last  = out_q.last;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(in_ready));

    a_stall_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id) && $stable(out_last)));

endmodule

// File: tb/tb_valid_ready_rr_arbiter.sv
// Randomised and directed checks of valid_ready_rr_arbiter against a packet-level reference model.
module tb_valid_ready_rr_arbiter;
    import datatypes_globals_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    rtl_data_t [N-1:0] in_data;
    logic [N-1:0]      in_last;
    logic              out_valid;
    logic              out_ready;
    rtl_data_t         out_data;
    logic [1:0]        out_id;
    logic              out_last;

    always #5 clk = ~clk;

    valid_ready_rr_arbiter #(
        .DATA_T       (rtl_data_t),
        .NUM_REQ      (N),
        .REQ_ID_WIDTH (2),
        .MAX_BURST    (MB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    typedef struct {
        int        id;
        bit        last;
        rtl_data_t data;
    } beat_s;

    beat_s em[$];
    int    checks = 0;
    int    passed = 0;

    // Requester drivers: remaining beats of the current packet, queued packet lengths, idle gaps.
    int        rem[N];
    int        gap[N];
    rtl_data_t cur[N];
    int        plen[N][$];
    int        gap_pct = 0;

    // Reference model: who owns the grant, how many beats it has sent, what the output register holds.
    bit        m_lock, m_ov, m_ol;
    int        m_lid, m_cnt, m_prev, m_oid;
    rtl_data_t m_od;
    logic [N-1:0] exp_rdy, s_acc_m, s_acc_d, s_last;
    rtl_data_t s_data[N];
    logic      s_ordy;

    task automatic model_reset();
        m_lock = 0; m_ov = 0; m_ol = 0;
        m_lid = 0; m_cnt = 0; m_prev = N - 1; m_oid = 0; m_od = '0;
    endtask

    task automatic model_ready();
        int c;
        bit found = 0;
        exp_rdy = '0;
        if (reset_n && (!m_ov || out_ready)) begin
            if (m_lock) exp_rdy = N'(1) << m_lid;
            else begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_prev + k) % N;
                    if (!found && in_valid[2'(c)]) begin
                        exp_rdy = N'(1) << c;
                        found = 1;
                    end
                end
            end
        end
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (rem[r] == 0 && plen[r].size() > 0) rem[r] = plen[r].pop_front();
            in_valid[2'(r)] = (rem[r] > 0) && (gap[r] == 0);
            in_last[2'(r)]  = (rem[r] == 1);
            in_data[2'(r)]  = cur[r];
        end
    endtask

    task automatic clear_drv();
        for (int r = 0; r < N; r++) begin
            rem[r] = 0; gap[r] = 0; plen[r].delete();
            cur[r] = rtl_data_t'($urandom);
        end
        drive_inputs();
    endtask

    // Sample point: away from the active edge, inputs stable since posedge+1.
    task automatic half_a();
        @(negedge clk);
        model_ready();
        s_acc_m = in_valid & exp_rdy;
        s_acc_d = in_valid & in_ready;
        s_last  = in_last;
        s_ordy  = out_ready;
        for (int r = 0; r < N; r++) s_data[r] = in_data[2'(r)];
        if (out_valid && out_ready) em.push_back('{int'(out_id), out_last, out_data});
    endtask

    task automatic half_b();
        int c = 0;
        bit e;
        @(posedge clk);
        if (!reset_n) model_reset();
        else if (s_acc_m != '0) begin
            for (int r = 0; r < N; r++) if (s_acc_m[2'(r)]) c = r;
            e = s_last[2'(c)] || (MB != 0 && m_cnt == MB - 1);
            m_ov = 1; m_od = s_data[c]; m_oid = c; m_prev = c; m_ol = e;
            if (e) begin m_lock = 0; m_cnt = 0; end
            else begin m_lock = 1; m_lid = c; m_cnt++; end
        end else if (s_ordy) m_ov = 0;
        for (int r = 0; r < N; r++) begin
            if (s_acc_d[2'(r)]) begin
                rem[r]--;
                cur[r] = rtl_data_t'($urandom);
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap[r] = int'($urandom_range(3, 1));
            end else if (gap[r] > 0) gap[r]--;
        end
        #1 drive_inputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        out_ready = 1'b1;
        gap_pct = 0;
        clear_drv();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        em.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b1; out_ready = 1'b1;
        clear_drv();
        #1 reset_n = 1'b0;
        in_valid = '1;
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h want=00", out_data); else passed++;
        checks++; if (out_id !== 2'd0) $display("FAIL reset_out_id got=%0d want=0", out_id); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b want=0", out_last); else passed++;
        checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got=%b want=0000", in_ready); else passed++;
        do_reset();
    endtask

    task automatic test_alternate();
        do_reset();
        plen[0] = '{1, 1, 1, 1};
        plen[2] = '{1, 1, 1, 1};
        drive_inputs();
        for (int k = 0; k < 9; k++) begin
            half_a();
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== ((k % 2 == 1) ? 2'd0 : 2'd2) || out_last !== 1'b1)
                    $display("FAIL alternate cycle=%0d valid=%b id=%0d last=%b want valid=1 id=%0d last=1",
                             k, out_valid, out_id, out_last, (k % 2 == 1) ? 0 : 2);
                else passed++;
            end
            half_b();
        end
    endtask

    task automatic test_packet_lock();
        int exp_id[4]   = '{1, 1, 1, 3};
        bit exp_last[4] = '{0, 0, 1, 1};
        do_reset();
        plen[1] = '{3};
        plen[3] = '{1};
        drive_inputs();
        for (int k = 0; k < 7; k++) begin
            half_a();
            if (k < 3) begin
                checks++;
                if (in_ready !== 4'b0010) $display("FAIL lock_ready cycle=%0d got=%b want=0010", k, in_ready);
                else passed++;
            end
            half_b();
        end
        checks++; if (em.size() != 4) $display("FAIL lock_beats got=%0d want=4", em.size()); else passed++;
        for (int i = 0; i < 4 && i < em.size(); i++) begin
            checks++;
            if (em[i].id != exp_id[i] || em[i].last != exp_last[i])
                $display("FAIL lock_seq beat=%0d id=%0d last=%b want id=%0d last=%b", i, em[i].id, em[i].last, exp_id[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_burst_split();
        int exp_id[8]   = '{0, 0, 0, 0, 1, 1, 0, 0};
        bit exp_last[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
        do_reset();
        plen[0] = '{6};
        plen[1] = '{2};
        drive_inputs();
        repeat (12) begin half_a(); half_b(); end
        checks++; if (em.size() != 8) $display("FAIL burst_beats got=%0d want=8", em.size()); else passed++;
        for (int i = 0; i < 8 && i < em.size(); i++) begin
            checks++;
            if (em[i].id != exp_id[i] || em[i].last != exp_last[i])
                $display("FAIL burst_seq beat=%0d id=%0d last=%b want id=%0d last=%b", i, em[i].id, em[i].last, exp_id[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cur[2] = 8'hA5;
        plen[2] = '{1};
        drive_inputs();
        half_a(); half_b();
        out_ready = 1'b0;
        plen[0] = '{1};
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            half_a();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_id !== 2'd2 || out_last !== 1'b1 || in_ready !== 4'b0000)
                $display("FAIL stall cycle=%0d valid=%b data=%h id=%0d last=%b rdy=%b want 1 a5 2 1 0000",
                         k, out_valid, out_data, out_id, out_last, in_ready);
            else passed++;
            half_b();
        end
        out_ready = 1'b1;
        half_a();
        checks++; if (in_ready !== 4'b0001) $display("FAIL resume_ready got=%b want=0001", in_ready); else passed++;
        half_b();
        half_a();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) $display("FAIL resume_beat valid=%b id=%0d want valid=1 id=0", out_valid, out_id);
        else passed++;
        half_b();
    endtask

    task automatic test_valid_gap();
        int bubbles = 0;
        int exp_id[5]   = '{1, 1, 1, 1, 0};
        bit exp_last[5] = '{0, 0, 0, 1, 1};
        do_reset();
        plen[1] = '{4};
        drive_inputs();
        half_a(); half_b();
        gap[1] = 3;
        plen[0] = '{1};
        drive_inputs();
        for (int k = 0; k < 10; k++) begin
            half_a();
            if (k < 7 && out_valid !== 1'b1) bubbles++;
            if (k < 3) begin
                checks++;
                if (in_ready[0] !== 1'b0) $display("FAIL gap_ready0 cycle=%0d got=%b want=0", k, in_ready[0]);
                else passed++;
            end
            half_b();
        end
        checks++; if (bubbles != 3) $display("FAIL gap_bubbles got=%0d want=3", bubbles); else passed++;
        checks++; if (em.size() != 5) $display("FAIL gap_beats got=%0d want=5", em.size()); else passed++;
        for (int i = 0; i < 5 && i < em.size(); i++) begin
            checks++;
            if (em[i].id != exp_id[i] || em[i].last != exp_last[i])
                $display("FAIL gap_seq beat=%0d id=%0d last=%b want id=%0d last=%b", i, em[i].id, em[i].last, exp_id[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        plen[2] = '{5};
        drive_inputs();
        repeat (2) begin half_a(); half_b(); end
        #2 reset_n = 1'b0;
        model_reset();
        clear_drv();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_last !== 1'b0 || in_ready !== 4'b0000)
            $display("FAIL midreset valid=%b id=%0d last=%b rdy=%b want 0 0 0 0000", out_valid, out_id, out_last, in_ready);
        else passed++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int r = 0; r < N; r++) plen[r] = '{1};
        drive_inputs();
        em.delete();
        repeat (6) begin half_a(); half_b(); end
        checks++; if (em.size() != 4) $display("FAIL midreset_beats got=%0d want=4", em.size()); else passed++;
        for (int i = 0; i < 4 && i < em.size(); i++) begin
            checks++;
            if (em[i].id != i) $display("FAIL midreset_order beat=%0d id=%0d want=%0d", i, em[i].id, i);
            else passed++;
        end
    endtask

    task automatic test_random();
        int total = 0;
        int cyc   = 0;
        do_reset();
        gap_pct = 30;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 3; p++) begin
                int len = int'($urandom_range(7, 1));
                plen[r].push_back(len);
                total += len;
            end
        end
        drive_inputs();
        while (em.size() < total && cyc < 3000) begin
            half_a();
            checks++;
            if (in_ready !== exp_rdy || out_valid !== m_ov ||
                (m_ov && (out_data !== m_od || out_id !== 2'(m_oid) || out_last !== m_ol)))
                $display("FAIL rand_cycle cyc=%0d rdy=%b/%b valid=%b/%b data=%h/%h id=%0d/%0d last=%b/%b",
                         cyc, in_ready, exp_rdy, out_valid, m_ov, out_data, m_od, out_id, m_oid, out_last, m_ol);
            else passed++;
            half_b();
            out_ready = ($urandom_range(3) != 0);
            cyc++;
        end
        checks++; if (em.size() != total) $display("FAIL rand_total got=%0d want=%0d", em.size(), total); else passed++;
        out_ready = 1'b1;
        gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_packet_lock();
        test_burst_split();
        test_backpressure();
        test_valid_gap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
